// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the dmem write-port arbiter.
// Imported by rr_pick and dmem_wr_arbiter.
package dmem_arb_pkg;

  localparam int N_REQ_DEF = 8;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  // Index width for n items, never below one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Successor of p in a ring of n slots.
  function automatic int rr_next(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Doubled request vector, masked below ptr, lowest set bit wins.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  act,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam int W2 = 2 * N;

  logic [W2-1:0] dbl;
  logic [W2-1:0] below;
  logic [W2-1:0] masked;
  logic [W2-1:0] first;

  assign dbl    = {act, act};
  assign below  = (W2'(1) << ptr) - W2'(1);
  assign masked = dbl & ~below;
  assign first  = masked & (~masked + W2'(1));
  assign gnt    = first[N-1:0] | first[W2-1:N];
  assign valid  = |act;

  // One-hot grant to binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dmem_wr_arbiter.sv
// Round-robin arbiter for the shared dmem write port, registered issue.
// Optional stall counters enabled by DMEM_ARB_STATS_EN.
module dmem_wr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         eligible,
  input  logic [N_REQ*AW-1:0]      a_in,
  input  logic [N_REQ*DW-1:0]      wd_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         stall,
  output logic                     we,
  output logic [AW-1:0]            a_out,
  output logic [DW-1:0]            wd_out,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [N_REQ*CNT_W-1:0]   stall_cnt
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] act;
  logic [N_REQ-1:0] pickGnt;
  logic [IW-1:0]    pickIdx;
  logic             pickValid;
  logic [IW-1:0]    ptr;

  assign act = req & eligible;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) uPick (
    .act   (act),
    .ptr   (ptr),
    .gnt   (pickGnt),
    .idx   (pickIdx),
    .valid (pickValid)
  );

  assign gnt   = reset ? '0 : pickGnt;
  assign stall = reset ? '0 : (act & ~pickGnt);

  // Issue register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      we     <= 1'b0;
      a_out  <= '0;
      wd_out <= '0;
      gnt_id <= '0;
      ptr    <= '0;
    end else if (pickValid) begin
      we     <= 1'b1;
      a_out  <= a_in[pickIdx*AW +: AW];
      wd_out <= wd_in[pickIdx*DW +: DW];
      gnt_id <= pickIdx;
      ptr    <= IW'(rr_next(int'(pickIdx), N_REQ));
    end else begin
      we <= 1'b0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  // Per-core saturating stall counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (stall[i] && !(&cnt[i])) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Flatten counters onto the probe port.
  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stall_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
